// File: rtl/ptp_bus_master_if.sv
// ptp_bus_master_if
// Groups the command, on-chip-bus and response signals of ptp_bus_master.
//   master modport : the view of the bus master itself (ptp_bus_master)
//   slave  modport : the view of whatever drives commands, sits on the bus
//                    and consumes responses
// Signals:
//   cmd_valid_i / cmd_ready_o        command handshake
//   cmd_wr_i, cmd_addr_i, cmd_data_i command fields (1 = write)
//   cmd_len_i                        read beats minus 1
//   bus2ip_addr_o / bus2ip_data_o    bus address and write data
//   bus2ip_rd_ce_o / bus2ip_wr_ce_o  one-cycle read / write strobes
//   ip2bus_data_i                    read data from the slave(s)
//   rsp_valid_o / rsp_ready_i        response handshake
//   rsp_data_o, rsp_last_o           read data, final-beat marker
//   busy_o                           high whenever the master is not idle
interface ptp_bus_master_if;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_wr_i;
    logic [31:0] cmd_addr_i;
    logic [31:0] cmd_data_i;
    logic [3:0]  cmd_len_i;
    logic [31:0] bus2ip_addr_o;
    logic [31:0] bus2ip_data_o;
    logic        bus2ip_rd_ce_o;
    logic        bus2ip_wr_ce_o;
    logic [31:0] ip2bus_data_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_data_o;
    logic        rsp_last_o;
    logic        busy_o;

    modport master (
        input  cmd_valid_i, cmd_wr_i, cmd_addr_i, cmd_data_i, cmd_len_i,
        input  ip2bus_data_i, rsp_ready_i,
        output cmd_ready_o, bus2ip_addr_o, bus2ip_data_o,
        output bus2ip_rd_ce_o, bus2ip_wr_ce_o,
        output rsp_valid_o, rsp_data_o, rsp_last_o, busy_o
    );

    modport slave (
        output cmd_valid_i, cmd_wr_i, cmd_addr_i, cmd_data_i, cmd_len_i,
        output ip2bus_data_i, rsp_ready_i,
        input  cmd_ready_o, bus2ip_addr_o, bus2ip_data_o,
        input  bus2ip_rd_ce_o, bus2ip_wr_ce_o,
        input  rsp_valid_o, rsp_data_o, rsp_last_o, busy_o
    );
endinterface

// File: rtl/ptp_bus_master.sv
// ptp_bus_master
// Turns single commands into on-chip-bus accesses: a write becomes one
// wr_ce pulse, a read becomes 1..16 rd_ce beats at incrementing addresses,
// each beat returned as one response. One access is outstanding at a time.
// Ports:
//   bus2ip_clk  clock, rising edge
//   bus2ip_rst  asynchronous active-high reset
//   bus         ptp_bus_master_if.master (command, bus and response signals)
// Parameters:
//   RD_LAT      cycles from the rd_ce cycle to valid ip2bus_data_i (1..7)
//   ADDR_INC    byte-address step between burst beats
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | ready for a command
// S_WR   | wr_ce pulse on the bus
// S_RD   | rd_ce pulse on the bus (cycle C)
// S_WAIT | waiting RD_LAT cycles; data sampled on the edge ending C+RD_LAT
// S_RSP  | response presented, held until rsp_ready_i
module ptp_bus_master #(
    parameter int unsigned RD_LAT   = 1,
    parameter logic [31:0] ADDR_INC = 32'd4
) (
    input  logic             bus2ip_clk,
    input  logic             bus2ip_rst,
    ptp_bus_master_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_WAIT,
        S_RSP
    } state_t;

    // WAIT lasts RD_LAT cycles, so the down-counter starts at RD_LAT-1.
    localparam logic [2:0] LAT_LOAD = 3'(RD_LAT - 1);

    state_t      state, state_nxt;
    logic [3:0]  beat_cnt;
    logic [2:0]  lat_cnt;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [31:0] rsp_data_q;
    logic        rd_ce_q;
    logic        wr_ce_q;

    logic accept;
    logic sample;
    logic rsp_hs;
    logic advance;

    assign accept  = (state == S_IDLE) && bus.cmd_valid_i;
    assign sample  = (state == S_WAIT) && (lat_cnt == 3'd0);
    assign rsp_hs  = (state == S_RSP) && bus.rsp_ready_i;
    assign advance = rsp_hs && (beat_cnt != 4'd0);

    always_ff @(posedge bus2ip_clk or posedge bus2ip_rst) begin
        if (bus2ip_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (bus.cmd_valid_i) begin
                    state_nxt = bus.cmd_wr_i ? S_WR : S_RD;
                end
            end
            S_WR:   state_nxt = S_IDLE;
            S_RD:   state_nxt = S_WAIT;
            S_WAIT: begin
                if (lat_cnt == 3'd0) begin
                    state_nxt = S_RSP;
                end
            end
            S_RSP: begin
                if (bus.rsp_ready_i) begin
                    state_nxt = (beat_cnt == 4'd0) ? S_IDLE : S_RD;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge bus2ip_clk or posedge bus2ip_rst) begin
        if (bus2ip_rst) begin
            beat_cnt   <= 4'd0;
            lat_cnt    <= 3'd0;
            addr_q     <= 32'd0;
            data_q     <= 32'd0;
            rsp_data_q <= 32'd0;
            rd_ce_q    <= 1'b0;
            wr_ce_q    <= 1'b0;
        end else begin
            if (accept) begin
                addr_q   <= bus.cmd_addr_i;
                beat_cnt <= bus.cmd_wr_i ? 4'd0 : bus.cmd_len_i;
                if (bus.cmd_wr_i) begin
                    data_q <= bus.cmd_data_i;
                end
            end else if (advance) begin
                // Wraps modulo 2^32 by plain 32-bit addition.
                addr_q   <= addr_q + ADDR_INC;
                beat_cnt <= beat_cnt - 4'd1;
            end

            if (state == S_RD) begin
                lat_cnt <= LAT_LOAD;
            end else if ((state == S_WAIT) && (lat_cnt != 3'd0)) begin
                lat_cnt <= lat_cnt - 3'd1;
            end

            // Slaves are OR-combined upstream, so only this one edge matters.
            if (sample) begin
                rsp_data_q <= bus.ip2bus_data_i;
            end

            // Strobes come straight from flops: each is high exactly in its
            // own single-cycle state, so they can never overlap.
            rd_ce_q <= (state_nxt == S_RD);
            wr_ce_q <= (state_nxt == S_WR);
        end
    end

    assign bus.cmd_ready_o    = (state == S_IDLE);
    assign bus.busy_o         = (state != S_IDLE);
    assign bus.bus2ip_addr_o  = addr_q;
    assign bus.bus2ip_data_o  = data_q;
    assign bus.bus2ip_rd_ce_o = rd_ce_q;
    assign bus.bus2ip_wr_ce_o = wr_ce_q;
    assign bus.rsp_valid_o    = (state == S_RSP);
    assign bus.rsp_data_o     = rsp_data_q;
    assign bus.rsp_last_o     = (state == S_RSP) && (beat_cnt == 4'd0);

endmodule

// File: tb/tb_ptp_bus_master.sv
module tb_ptp_bus_master;

    logic clk;
    logic rst;

    ptp_bus_master_if bus1();
    ptp_bus_master_if bus3();

    ptp_bus_master #(.RD_LAT(1), .ADDR_INC(32'd4)) u_dut (
        .bus2ip_clk(clk),
        .bus2ip_rst(rst),
        .bus(bus1)
    );

    ptp_bus_master #(.RD_LAT(3), .ADDR_INC(32'd4)) u_dut3 (
        .bus2ip_clk(clk),
        .bus2ip_rst(rst),
        .bus(bus3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] slave_word(input logic [31:0] a);
        if (a == 32'h0000_0020) return 32'h1234_5678;
        return a ^ 32'hC3C3_0000;
    endfunction

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } rsp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    rsp_t        rsp_q[$];
    logic [31:0] rd_q[$];
    wr_t         wr_q[$];
    rsp_t        rsp3_q[$];

    // Slave models: data is valid only on cycle C+RD_LAT, garbage otherwise.
    logic        v1[0:3];
    logic [31:0] a1[0:3];
    logic        v3[0:3];
    int          gcnt = 0;

    initial begin
        for (int i = 0; i < 4; i++) begin
            v1[i] = 1'b0;
            a1[i] = 32'd0;
            v3[i] = 1'b0;
        end
        bus1.ip2bus_data_i = 32'd0;
        bus3.ip2bus_data_i = 32'd0;
    end

    always @(negedge clk) begin
        gcnt++;
        for (int i = 3; i > 0; i--) begin
            v1[i] = v1[i-1];
            a1[i] = a1[i-1];
            v3[i] = v3[i-1];
        end
        v1[0] = bus1.bus2ip_rd_ce_o;
        a1[0] = bus1.bus2ip_addr_o;
        v3[0] = bus3.bus2ip_rd_ce_o;
        bus1.ip2bus_data_i = v1[1] ? slave_word(a1[1]) : (32'hBAD0_0000 | 32'(gcnt));
        if (v3[3])      bus3.ip2bus_data_i = 32'h3333_3333;
        else if (v3[2]) bus3.ip2bus_data_i = 32'h2222_2222;
        else if (v3[1]) bus3.ip2bus_data_i = 32'h1111_1111;
        else            bus3.ip2bus_data_i = 32'hBAD0_0000 | 32'(gcnt);
    end

    // Monitor for the RD_LAT=1 instance.
    int   cyc1 = 0;
    int   last_rd1 = 0;
    int   rd_cnt1 = 0;
    logic prev_wr1 = 1'b0;
    logic prev_valid1 = 1'b0;

    always @(negedge clk) begin
        cyc1++;
        if (bus1.bus2ip_rd_ce_o || bus1.bus2ip_wr_ce_o)
            chk("strobe_excl", 32'(bus1.bus2ip_rd_ce_o & bus1.bus2ip_wr_ce_o), 32'd0);
        if (bus1.bus2ip_rd_ce_o) begin
            rd_cnt1++;
            last_rd1 = cyc1;
            if (rd_q.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
            else chk("rd_addr", bus1.bus2ip_addr_o, rd_q.pop_front());
        end
        if (bus1.bus2ip_wr_ce_o) begin
            chk("wr_width", 32'(prev_wr1), 32'd0);
            if (wr_q.size() == 0) chk("wr_unexpected", 32'd1, 32'd0);
            else begin
                wr_t w;
                w = wr_q.pop_front();
                chk("wr_addr", bus1.bus2ip_addr_o, w.addr);
                chk("wr_data", bus1.bus2ip_data_o, w.data);
            end
        end
        if (bus1.rsp_valid_o) begin
            if (!prev_valid1) chk("rsp_latency", 32'(cyc1 - last_rd1), 32'd2);
            if (rsp_q.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
            else begin
                chk("rsp_data", bus1.rsp_data_o, rsp_q[0].data);
                chk("rsp_last", 32'(bus1.rsp_last_o), 32'(rsp_q[0].last));
                if (bus1.rsp_ready_i) void'(rsp_q.pop_front());
            end
        end
        prev_wr1    = bus1.bus2ip_wr_ce_o;
        prev_valid1 = bus1.rsp_valid_o;
    end

    // Monitor for the RD_LAT=3 instance.
    int   cyc3 = 0;
    int   last_rd3 = 0;
    logic prev_valid3 = 1'b0;

    always @(negedge clk) begin
        cyc3++;
        if (bus3.bus2ip_rd_ce_o) last_rd3 = cyc3;
        if (bus3.rsp_valid_o) begin
            if (!prev_valid3) chk("lat3_latency", 32'(cyc3 - last_rd3), 32'd4);
            if (rsp3_q.size() == 0) chk("lat3_unexpected", 32'd1, 32'd0);
            else begin
                chk("lat3_data", bus3.rsp_data_o, rsp3_q[0].data);
                chk("lat3_last", 32'(bus3.rsp_last_o), 32'(rsp3_q[0].last));
                if (bus3.rsp_ready_i) void'(rsp3_q.pop_front());
            end
        end
        prev_valid3 = bus3.rsp_valid_o;
    end

    // Inputs change only at posedge+1, so monitors see them stable.
    task automatic send(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] len, input bit expect_rsp, output int waited);
        int n;
        if (wr) begin
            wr_t w;
            w.addr = a;
            w.data = d;
            wr_q.push_back(w);
        end else if (expect_rsp) begin
            for (int i = 0; i <= int'(len); i++) begin
                rsp_t r;
                logic [31:0] ab;
                ab = a + 32'(i) * 32'd4;
                rd_q.push_back(ab);
                r.data = slave_word(ab);
                r.last = (i == int'(len));
                rsp_q.push_back(r);
            end
        end
        bus1.cmd_valid_i = 1'b1;
        bus1.cmd_wr_i    = wr;
        bus1.cmd_addr_i  = a;
        bus1.cmd_data_i  = d;
        bus1.cmd_len_i   = len;
        n = 0;
        while (!bus1.cmd_ready_o && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 50) chk("cmd_accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        bus1.cmd_valid_i = 1'b0;
        bus1.cmd_wr_i    = ~wr;
        bus1.cmd_addr_i  = ~a;
        bus1.cmd_data_i  = ~d;
        bus1.cmd_len_i   = ~len;
        waited = n;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((bus1.busy_o || bus1.rsp_valid_o) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 300) chk(name, 32'd0, 32'd1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_addr"},   bus1.bus2ip_addr_o, 32'd0);
        chk({tag, "_data"},   bus1.bus2ip_data_o, 32'd0);
        chk({tag, "_rd_ce"},  32'(bus1.bus2ip_rd_ce_o), 32'd0);
        chk({tag, "_wr_ce"},  32'(bus1.bus2ip_wr_ce_o), 32'd0);
        chk({tag, "_rsp_v"},  32'(bus1.rsp_valid_o), 32'd0);
        chk({tag, "_rsp_d"},  bus1.rsp_data_o, 32'd0);
        chk({tag, "_rsp_l"},  32'(bus1.rsp_last_o), 32'd0);
        chk({tag, "_busy"},   32'(bus1.busy_o), 32'd0);
        chk({tag, "_ready"},  32'(bus1.cmd_ready_o), 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int w;
        int rc;
        int cnt_v;
        int cnt_r;
        int n;

        rst = 1'b1;
        bus1.cmd_valid_i = 1'b0;
        bus1.cmd_wr_i    = 1'b0;
        bus1.cmd_addr_i  = 32'd0;
        bus1.cmd_data_i  = 32'd0;
        bus1.cmd_len_i   = 4'd0;
        bus1.rsp_ready_i = 1'b1;
        bus3.cmd_valid_i = 1'b0;
        bus3.cmd_wr_i    = 1'b0;
        bus3.cmd_addr_i  = 32'd0;
        bus3.cmd_data_i  = 32'd0;
        bus3.cmd_len_i   = 4'd0;
        bus3.rsp_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset("rst");
        rst = 1'b0;

        // First command after reset goes in on the first edge.
        send(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'd0, 1'b0, w);
        chk("first_accept_wait", 32'(w), 32'd0);
        chk("wr_ce_on",     32'(bus1.bus2ip_wr_ce_o), 32'd1);
        chk("wr_addr_now",  bus1.bus2ip_addr_o, 32'h0000_0010);
        chk("wr_data_now",  bus1.bus2ip_data_o, 32'hDEAD_BEEF);
        chk("wr_ready_low", 32'(bus1.cmd_ready_o), 32'd0);
        chk("wr_no_rsp",    32'(bus1.rsp_valid_o), 32'd0);
        @(posedge clk); #1;
        chk("wr_ce_off",     32'(bus1.bus2ip_wr_ce_o), 32'd0);
        chk("wr_ready_back", 32'(bus1.cmd_ready_o), 32'd1);
        chk("wr_addr_hold",  bus1.bus2ip_addr_o, 32'h0000_0010);

        // Single read.
        rc = rd_cnt1;
        send(1'b0, 32'h0000_0020, 32'd0, 4'd0, 1'b1, w);
        wait_idle("single_rd_timeout");
        chk("single_rd_count", 32'(rd_cnt1 - rc), 32'd1);

        // Burst across the 32-bit address wrap.
        rc = rd_cnt1;
        send(1'b0, 32'hFFFF_FFF8, 32'd0, 4'd3, 1'b1, w);
        wait_idle("burst_timeout");
        chk("burst_rd_count", 32'(rd_cnt1 - rc), 32'd4);

        // Stall on beat 1 for 10 cycles.
        bus1.rsp_ready_i = 1'b0;
        rc = rd_cnt1;
        send(1'b0, 32'h0000_0100, 32'd0, 4'd1, 1'b1, w);
        n = 0;
        while (!bus1.rsp_valid_o && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 20) chk("stall_valid_timeout", 32'd0, 32'd1);
        repeat (10) @(posedge clk);
        #1;
        chk("stall_rd_count",   32'(rd_cnt1 - rc), 32'd1);
        chk("stall_valid_held", 32'(bus1.rsp_valid_o), 32'd1);
        bus1.rsp_ready_i = 1'b1;
        wait_idle("stall_timeout");
        chk("stall_rd_total", 32'(rd_cnt1 - rc), 32'd2);

        // Reset during WAIT of a len-7 burst.
        rd_q.push_back(32'h0000_0200);
        send(1'b0, 32'h0000_0200, 32'd0, 4'd7, 1'b0, w);
        @(posedge clk); #1;
        chk("abort_busy", 32'(bus1.busy_o), 32'd1);
        rst = 1'b1;
        #1;
        chk_reset("abort");
        @(posedge clk); #1;
        rst = 1'b0;
        cnt_v = 0;
        cnt_r = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus1.rsp_valid_o)    cnt_v++;
            if (bus1.bus2ip_rd_ce_o) cnt_r++;
        end
        chk("abort_no_rsp", 32'(cnt_v), 32'd0);
        chk("abort_no_rd",  32'(cnt_r), 32'd0);
        send(1'b1, 32'h0000_0044, 32'h55AA_55AA, 4'd0, 1'b0, w);
        wait_idle("post_abort_wr_timeout");
        chk("post_abort_addr", bus1.bus2ip_addr_o, 32'h0000_0044);
        chk("post_abort_data", bus1.bus2ip_data_o, 32'h55AA_55AA);

        // RD_LAT=3: only the value on rd_ce+3 may be captured.
        begin
            rsp_t r;
            r.data = 32'h3333_3333;
            r.last = 1'b0;
            rsp3_q.push_back(r);
            r.last = 1'b1;
            rsp3_q.push_back(r);
        end
        bus3.cmd_valid_i = 1'b1;
        bus3.cmd_wr_i    = 1'b0;
        bus3.cmd_addr_i  = 32'h0000_0040;
        bus3.cmd_len_i   = 4'd1;
        @(posedge clk); #1;
        bus3.cmd_valid_i = 1'b0;
        n = 0;
        while ((bus3.busy_o || bus3.rsp_valid_o) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 100) chk("lat3_timeout", 32'd0, 32'd1);
        chk("lat3_addr_end", bus3.bus2ip_addr_o, 32'h0000_0044);

        repeat (3) @(posedge clk);
        #1;
        chk("rsp_q_left",  32'(rsp_q.size()), 32'd0);
        chk("rd_q_left",   32'(rd_q.size()), 32'd0);
        chk("wr_q_left",   32'(wr_q.size()), 32'd0);
        chk("rsp3_q_left", 32'(rsp3_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ptp_bus_master.md
PTP_BUS_MASTER -- requirements
Module: ptp_bus_master

Interface
REQ-001 Parameter RD_LAT, default 1: cycles from the rd_ce cycle until ip2bus_data_i is valid; legal range 1..7.
REQ-002 Parameter ADDR_INC, default 4: byte-address increment between burst read beats.
REQ-003 bus2ip_clk  input  1  single clock; all logic on its rising edge.
REQ-004 bus2ip_rst  input  1  reset; asynchronous, active-high.
REQ-005 cmd_valid_i  input  1  command offered.
REQ-006 cmd_ready_o  output  1  command accepted when cmd_valid_i & cmd_ready_o are high at a clock edge.
REQ-007 cmd_wr_i  input  1  1 = write, 0 = read.
REQ-008 cmd_addr_i  input  32  start byte address.
REQ-009 cmd_data_i  input  32  write data.
REQ-010 cmd_len_i  input  4  read beats minus 1; ignored for writes.
REQ-011 bus2ip_addr_o  output  32  on-chip-bus address.
REQ-012 bus2ip_data_o  output  32  on-chip-bus write data.
REQ-013 bus2ip_rd_ce_o  output  1  read strobe, active high.
REQ-014 bus2ip_wr_ce_o  output  1  write strobe, active high.
REQ-015 ip2bus_data_i  input  32  read data returned by the slave(s).
REQ-016 rsp_valid_o  output  1  read response available.
REQ-017 rsp_ready_i  input  1  response consumed when rsp_valid_o & rsp_ready_i are high at a clock edge.
REQ-018 rsp_data_o  output  32  read data.
REQ-019 rsp_last_o  output  1  marks the final beat of a burst.
REQ-020 busy_o  output  1  high in every state except IDLE.

Function
REQ-021 FSM states: IDLE, WR, RD, WAIT, RSP.
REQ-022 cmd_ready_o = 1 only in IDLE; there is no command buffering.
REQ-023 IDLE, write accepted: go to WR; latch addr/data onto bus2ip_addr_o/bus2ip_data_o.
REQ-024 WR: bus2ip_wr_ce_o high for exactly one cycle, then return to IDLE; no response is generated.
REQ-025 IDLE, read accepted: latch the address and a beat counter = cmd_len_i; go to RD.
REQ-026 RD: bus2ip_rd_ce_o high for exactly one cycle (cycle C); go to WAIT.
REQ-027 WAIT: count RD_LAT cycles.
REQ-028 Read data sampling: ip2bus_data_i is sampled into rsp_data_o at the edge ending cycle C+RD_LAT.
REQ-029 The FSM enters RSP with rsp_valid_o high from cycle C+RD_LAT+1.
REQ-030 RSP: rsp_valid_o, rsp_data_o and rsp_last_o are held stable until handshake.
REQ-031 RSP handshake, counter = 0: go to IDLE.
REQ-032 RSP handshake, counter > 0: decrement the counter, add ADDR_INC to the address modulo 2^32 (0xFFFFFFFC+4 = 0x00000000), go to RD.
REQ-033 Only one read is outstanding at a time; rsp_ready_i held low stalls the FSM indefinitely, with no further rd_ce.
REQ-034 rsp_last_o = 1 exactly when the counter = 0 in RSP.
REQ-035 bus2ip_rd_ce_o and bus2ip_wr_ce_o are never high in the same cycle.
REQ-036 Each strobe is registered and is one cycle wide.
REQ-037 bus2ip_addr_o and bus2ip_data_o hold their last values between accesses.
REQ-038 Slave read data is OR-combined upstream; ip2bus_data_i outside the sample edge is ignored.
REQ-039 cmd_* inputs are ignored outside IDLE.
REQ-040 cmd_len_i is sampled only at acceptance.

Reset
REQ-041 While bus2ip_rst = 1, the FSM is in IDLE and counters are zero.
REQ-042 Output reset values: bus2ip_addr_o = 0, bus2ip_data_o = 0, both strobes = 0, rsp_valid_o = 0, rsp_data_o = 0, rsp_last_o = 0, busy_o = 0, cmd_ready_o = 1.
REQ-043 Reset asserted mid-burst aborts immediately; pending beats and responses are discarded.
REQ-044 After deassertion, the first command is accepted on the first edge with cmd_valid_i high.

Verification
REQ-045 Write 0x0000_0010 <- 0xDEAD_BEEF -> next cycle: addr 0x10, data 0xDEADBEEF, wr_ce high for 1 cycle; no rsp_valid; cmd_ready_o back high the cycle after.
REQ-046 Read 0x0000_0020, len 0, RD_LAT 1, slave returns 0x1234_5678 the cycle after rd_ce -> rsp_valid_o 2 cycles after rd_ce; data 0x12345678; rsp_last_o = 1.
REQ-047 Read burst 0xFFFF_FFF8, len 3, rsp_ready_i held high -> 4 rd_ce pulses at addrs FFFFFFF8, FFFFFFFC, 00000000, 00000004; rsp_last_o only on beat 4.
REQ-048 Burst len 1 with rsp_ready_i low for 10 cycles on beat 1 -> rsp_data stable for those cycles; no second rd_ce until handshake.
REQ-049 RD_LAT 3 -> data is taken from the third cycle after rd_ce; a value driven only on cycle +1 is not captured.
REQ-050 Reset asserted during WAIT of a len-7 burst -> all outputs at reset values the same cycle; no rsp_valid_o after release; a new write then completes normally.
